// File: rtl/zmod_pkg.sv
// zmod_pkg: shared PRBS-7 types and helpers for the ZMOD LVDS loopback link
//   zmod_chk_state_t : receive checker state
//   prbs7_step4      : advances a 7-bit history by one 4-bit word, returns {h_next, e[3:0]}
package zmod_pkg;
   typedef enum logic {SEARCH, LOCKED} zmod_chk_state_t;
   localparam int PRBS7_TAP_A = 6;
   localparam int PRBS7_TAP_B = 5;
   function automatic logic [10:0] prbs7_step4(input logic [6:0] h, input logic [3:0] d);
      logic [6:0] t;
      logic [3:0] e;
      t = h;
      for (int i = 3; i >= 0; i--) begin
         e[i] = d[i] ^ t[PRBS7_TAP_A] ^ t[PRBS7_TAP_B];
         // received bit feeds back so the checker self-synchronises
         t = {t[5:0], d[i]};
      end
      return {t, e};
   endfunction
endpackage

// File: rtl/zmod_rx_checker.sv
// zmod_rx_checker: self-synchronising PRBS-7 receive checker with lock FSM and saturating counters
//   base_clk/reset_n        : clock, async active-low reset
//   rx_data/rx_valid        : 4-bit received word (bit 3 earliest) and its strobe
//   clear_counts            : synchronous clear of err_bits and words
//   locked/err_pulse        : lock status, one-cycle pulse per errored word while locked
//   err_bits/words          : saturating bit-error and word counts accumulated while locked
module zmod_rx_checker
   import zmod_pkg::*;
#(
   parameter int LOCK_WORDS = 16,
   parameter int LOSS_WORDS = 4,
   parameter int CNT_W = 32
) (
   input  logic             base_clk,
   input  logic             reset_n,
   input  logic [3:0]       rx_data,
   input  logic             rx_valid,
   input  logic             clear_counts,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_bits,
   output logic [CNT_W-1:0] words
);
   localparam logic [7:0] LOCK_N = 8'(LOCK_WORDS);
   localparam logic [7:0] LOSS_N = 8'(LOSS_WORDS);
   zmod_chk_state_t state, state_n;
   logic [6:0] h, h_n, h_step;
   logic [3:0] e;
   logic [2:0] nerr;
   logic [7:0] good_cnt, good_n, bad_cnt, bad_n;
   logic [CNT_W:0] eb_sum;
   logic [CNT_W-1:0] eb_n, wd_n;
   logic pulse_n, clean;
   always_ff @(posedge base_clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= SEARCH;
         h <= '0;
         good_cnt <= '0;
         bad_cnt <= '0;
         err_pulse <= 1'b0;
         err_bits <= '0;
         words <= '0;
      end else begin
         state <= state_n;
         h <= h_n;
         good_cnt <= good_n;
         bad_cnt <= bad_n;
         err_pulse <= pulse_n;
         err_bits <= eb_n;
         words <= wd_n;
      end
   end
   always_comb begin
      {h_step, e} = prbs7_step4(h, rx_data);
      nerr = 3'(e[0]) + 3'(e[1]) + 3'(e[2]) + 3'(e[3]);
      // an all-zero history is the PRBS lock-up state, so zero traffic never counts as clean
      clean = (e == 4'd0) && (h_step != 7'd0);
      eb_sum = {1'b0, err_bits} + (CNT_W+1)'(nerr);
      state_n = state;
      h_n = h;
      good_n = good_cnt;
      bad_n = bad_cnt;
      pulse_n = 1'b0;
      eb_n = err_bits;
      wd_n = words;
      if (rx_valid) begin
         h_n = h_step;
         if (state == SEARCH) begin
            good_n = clean ? good_cnt + 8'd1 : 8'd0;
            if (good_n == LOCK_N) begin
               state_n = LOCKED;
               bad_n = 8'd0;
            end
         end else begin
            bad_n = (nerr != 3'd0) ? bad_cnt + 8'd1 : 8'd0;
            pulse_n = nerr != 3'd0;
            eb_n = eb_sum[CNT_W] ? '1 : eb_sum[CNT_W-1:0];
            wd_n = (&words) ? words : words + 1'b1;
            if (bad_n == LOSS_N) begin
               state_n = SEARCH;
               good_n = 8'd0;
            end
         end
      end
      if (clear_counts) begin
         eb_n = '0;
         wd_n = '0;
      end
   end
   assign locked = state == LOCKED;
endmodule
